// File: rtl/i2c_cmd_frontend_pkg.sv
// -----------------------------------------------------------------------------
// i2c_flash_pkg
// Shared definitions for the I2C command front end and the flash command
// controller behind it:
//   - i2c_state_e : byte/ACK sequencing states of the I2C slave front end
//   - I2C_ACK / I2C_NACK : SDA level of an acknowledge / not-acknowledge bit
//   - unlock/command constants used by the controller and its test benches
//   - addr_inc() : 16-bit address increment with natural wrap to 16'h0000
// -----------------------------------------------------------------------------
package i2c_flash_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEVADDR   = 4'd1,
        ACK_DEV   = 4'd2,
        ADDR_HI   = 4'd3,
        ACK_HI    = 4'd4,
        ADDR_LO   = 4'd5,
        ACK_LO    = 4'd6,
        WDATA     = 4'd7,
        ACK_WDATA = 4'd8,
        RDATA     = 4'd9,
        RACK      = 4'd10,
        WAIT_STOP = 4'd11
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [15:0] ADDR_UNLOCK1 = 16'h5555;
    localparam logic [15:0] ADDR_UNLOCK2 = 16'hAAAA;
    localparam logic [7:0]  DATA_UNLOCK1 = 8'hAA;
    localparam logic [7:0]  DATA_UNLOCK2 = 8'h55;
    localparam logic [7:0]  CMD_WRITE    = 8'h20;
    localparam logic [7:0]  CMD_READ     = 8'h00;

    // Next sequential address; 16'hFFFF rolls over to 16'h0000.
    function automatic logic [15:0] addr_inc(input logic [15:0] addr);
        return addr + 16'd1;
    endfunction

endpackage

// File: rtl/i2c_cmd_frontend_if.sv
// -----------------------------------------------------------------------------
// i2c_cmd_frontend_if
// Bundles the I2C pad signals and the downstream command/read handshake of the
// I2C command front end.
//   scl_in, sda_in : raw bus levels from the pads
//   sda_oe         : 1 = pull SDA low (open drain), 0 = release
//   cmd_valid      : one-clock strobe, write data byte received
//   cmd_addr       : address for cmd_valid / rd_req
//   cmd_data       : data byte for cmd_valid
//   rd_req         : one-clock strobe, next read byte needed at cmd_addr
//   rd_data        : read byte, valid the clock after rd_req
//   busy           : high from START until STOP or reset
// Modports: slave = the front end, master = the pad/controller side.
// -----------------------------------------------------------------------------
interface i2c_cmd_frontend_if;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        rd_req;
    logic [7:0]  rd_data;
    logic        busy;

    modport slave (
        input  scl_in, sda_in, rd_data,
        output sda_oe, cmd_valid, cmd_addr, cmd_data, rd_req, busy
    );

    modport master (
        output scl_in, sda_in, rd_data,
        input  sda_oe, cmd_valid, cmd_addr, cmd_data, rd_req, busy
    );
endinterface

// File: rtl/i2c_cmd_frontend_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync
// Brings raw SCL/SDA into the clk domain and derives single-clock bus events.
//   clk, reset   : system clock, asynchronous active-high reset
//   scl_i, sda_i : raw pad levels
//   sda_o        : synchronised SDA level (the bit value at an SCL rise)
//   scl_rise_o   : SCL went 0 -> 1
//   scl_fall_o   : SCL went 1 -> 0
//   start_o      : SDA fell while SCL stayed high
//   stop_o       : SDA rose while SCL stayed high
// Event pulses are decoded from the last synchroniser stage and one history
// flop, so they are one clk wide and glitch free.
// -----------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Synchroniser chains plus one history stage; reset to the idle-bus level
    // (both lines high) so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_s & scl_prev_q;
    // SCL must be high in both samples so an SDA change next to an SCL edge
    // is never mistaken for START/STOP.
    assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_cmd_frontend.sv
// -----------------------------------------------------------------------------
// i2c_cmd_frontend
// I2C slave front end for the flash command controller. Decodes writes of the
// form dev-addr, addr-hi, addr-lo, data... into one-clock command strobes and
// serves reads by requesting bytes downstream and shifting them onto SDA.
//   clk   : system clock, at least 8x the SCL frequency
//   reset : asynchronous active-high reset
//   bus   : pad and command signals (see i2c_cmd_frontend_if, slave side)
// Parameters:
//   DEV_ADDR    : 7-bit slave address answered
//   SYNC_STAGES : synchroniser depth for SCL/SDA (>= 2)
// -----------------------------------------------------------------------------
module i2c_cmd_frontend
    import i2c_flash_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    i2c_cmd_frontend_if.slave bus
);

    logic        sda_s;
    logic        scl_rise_s;
    logic        scl_fall_s;
    logic        start_s;
    logic        stop_s;

    i2c_state_e  state_q;
    logic [7:0]  shreg_q;
    logic [7:0]  shreg_d;
    logic [2:0]  bit_cnt_q;
    logic        ack_phase_q;   // ACK states: ACK driven; RACK: master ACK seen
    logic        rw_q;
    logic        rd_wait_q;     // rd_data is valid this clk
    logic        sda_oe_q;
    logic        cmd_valid_q;
    logic        rd_req_q;
    logic        busy_q;
    logic [15:0] cmd_addr_q;
    logic [7:0]  cmd_data_q;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (bus.scl_in),
        .sda_i      (bus.sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise_s),
        .scl_fall_o (scl_fall_s),
        .start_o    (start_s),
        .stop_o     (stop_s)
    );

    // Byte being received including the bit sampled at this SCL rise.
    assign shreg_d = {shreg_q[6:0], sda_s};

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            ack_phase_q <= 1'b0;
            rw_q        <= 1'b0;
            rd_wait_q   <= 1'b0;
            sda_oe_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            rd_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_addr_q  <= 16'h0000;
            cmd_data_q  <= 8'h00;
        end else begin
            cmd_valid_q <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_wait_q   <= rd_req_q;
            // Post-increment one clk after the strobe so the strobe carries
            // the address the byte was written to.
            if (cmd_valid_q) begin
                cmd_addr_q <= addr_inc(cmd_addr_q);
            end

            if (stop_s) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                sda_oe_q    <= 1'b0;
                bit_cnt_q   <= 3'd0;
                ack_phase_q <= 1'b0;
            end else if (start_s) begin
                // Repeated START lands here too; cmd_addr is kept on purpose.
                state_q     <= DEVADDR;
                busy_q      <= 1'b1;
                sda_oe_q    <= 1'b0;
                bit_cnt_q   <= 3'd0;
                ack_phase_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, WAIT_STOP: begin
                        sda_oe_q <= 1'b0;
                    end

                    DEVADDR, ADDR_HI, ADDR_LO, WDATA: begin
                        if (scl_rise_s) begin
                            shreg_q   <= shreg_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                ack_phase_q <= 1'b0;
                                case (state_q)
                                    DEVADDR: begin
                                        if (shreg_d[7:1] == DEV_ADDR) begin
                                            rw_q    <= shreg_d[0];
                                            state_q <= ACK_DEV;
                                        end else begin
                                            state_q <= WAIT_STOP;
                                        end
                                    end
                                    ADDR_HI: begin
                                        cmd_addr_q[15:8] <= shreg_d;
                                        state_q          <= ACK_HI;
                                    end
                                    ADDR_LO: begin
                                        cmd_addr_q[7:0] <= shreg_d;
                                        state_q         <= ACK_LO;
                                    end
                                    WDATA: begin
                                        cmd_data_q  <= shreg_d;
                                        cmd_valid_q <= 1'b1;
                                        state_q     <= ACK_WDATA;
                                    end
                                    default: begin
                                        state_q <= IDLE;
                                    end
                                endcase
                            end
                        end
                    end

                    // First SCL fall ends bit 8 and starts the ACK; the second
                    // ends the ACK clock and releases SDA.
                    ACK_DEV, ACK_HI, ACK_LO, ACK_WDATA: begin
                        if (scl_fall_s) begin
                            if (!ack_phase_q) begin
                                sda_oe_q    <= (I2C_ACK == 1'b0);
                                ack_phase_q <= 1'b1;
                            end else begin
                                sda_oe_q    <= 1'b0;
                                ack_phase_q <= 1'b0;
                                bit_cnt_q   <= 3'd0;
                                case (state_q)
                                    ACK_DEV: begin
                                        if (rw_q) begin
                                            rd_req_q <= 1'b1;
                                            state_q  <= RDATA;
                                        end else begin
                                            state_q <= ADDR_HI;
                                        end
                                    end
                                    ACK_HI:    state_q <= ADDR_LO;
                                    ACK_LO:    state_q <= WDATA;
                                    ACK_WDATA: state_q <= WDATA;
                                    default:   state_q <= IDLE;
                                endcase
                            end
                        end
                    end

                    // The MSB goes out as soon as rd_data arrives, a few clks
                    // into the SCL low phase; later bits change on SCL fall.
                    RDATA: begin
                        if (rd_wait_q) begin
                            shreg_q   <= bus.rd_data;
                            sda_oe_q  <= ~bus.rd_data[7];
                            bit_cnt_q <= 3'd0;
                        end else if (scl_fall_s) begin
                            if (bit_cnt_q == 3'd7) begin
                                sda_oe_q    <= 1'b0;
                                ack_phase_q <= 1'b0;
                                state_q     <= RACK;
                            end else begin
                                shreg_q   <= {shreg_q[6:0], 1'b0};
                                sda_oe_q  <= ~shreg_q[6];
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end

                    RACK: begin
                        if (scl_rise_s && !ack_phase_q) begin
                            if (sda_s == I2C_ACK) begin
                                ack_phase_q <= 1'b1;
                            end else begin
                                state_q <= WAIT_STOP;
                            end
                        end else if (scl_fall_s && ack_phase_q) begin
                            cmd_addr_q  <= addr_inc(cmd_addr_q);
                            rd_req_q    <= 1'b1;
                            ack_phase_q <= 1'b0;
                            bit_cnt_q   <= 3'd0;
                            state_q     <= RDATA;
                        end
                    end

                    default: begin
                        state_q  <= IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_cmd_frontend.sv
// -----------------------------------------------------------------------------
// tb_i2c_cmd_frontend
// Bit-banged I2C master driving the front end through its interface. A passive
// monitor logs every cmd_valid and rd_req strobe; each test derives expected
// strobes and read bytes from the transaction it sent and compares.
// -----------------------------------------------------------------------------
module tb_i2c_cmd_frontend;
    import i2c_flash_pkg::*;

    localparam int Q = 6;   // clks per quarter SCL period

    logic clk = 1'b0;
    logic reset;
    logic scl_m;
    logic sda_m;
    logic sda_line;
    int   n_checks = 0;
    int   n_fail   = 0;

    i2c_cmd_frontend_if bus ();

    i2c_cmd_frontend #(
        .DEV_ADDR    (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Open-drain wired AND of master and slave.
    assign sda_line   = sda_m & ~bus.sda_oe;
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_line;

    // Read data source: the n-th request is served from rd_bytes[n-1 mod 8].
    logic [7:0] rd_bytes [8];
    int         rr_total = 0;
    logic [2:0] rd_ptr;
    assign rd_ptr      = 3'(rr_total - 1);
    assign bus.rd_data = rd_bytes[rd_ptr];

    logic [15:0] cv_addr [$];
    logic [7:0]  cv_data [$];
    logic [15:0] rr_addr [$];
    int          both_cnt = 0;
    int          oe_cnt   = 0;
    logic [7:0]  wr_buf [8];

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.cmd_valid) begin
            cv_addr.push_back(bus.cmd_addr);
            cv_data.push_back(bus.cmd_data);
        end
        if (bus.rd_req) begin
            rr_addr.push_back(bus.cmd_addr);
            rr_total = rr_total + 1;
        end
        if (bus.cmd_valid && bus.rd_req) both_cnt = both_cnt + 1;
        if (bus.sda_oe) oe_cnt = oe_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus driver tasks ----------------
    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_bit(input logic b, output logic seen);
        sda_m = b;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        wait_q();
        seen  = sda_line;
        scl_m = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic seen;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], seen);
        i2c_bit(1'b1, seen);
        acked = (seen == I2C_ACK);
    endtask

    task automatic read_byte(input logic master_bit, output logic [7:0] b, output logic rack_line);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, seen);
            b[i] = seen;
        end
        i2c_bit(master_bit, rack_line);
    endtask

    task automatic write_txn(input logic [7:0] dev, input logic [15:0] addr, input int n, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        send_byte(dev, a);        acks += int'(a);
        send_byte(addr[15:8], a); acks += int'(a);
        send_byte(addr[7:0], a);  acks += int'(a);
        for (int i = 0; i < n; i++) begin
            send_byte(wr_buf[i], a);
            acks += int'(a);
        end
        i2c_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.sda_oe, bus.cmd_valid, bus.rd_req, bus.busy, bus.cmd_addr, bus.cmd_data} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %h required 0", {bus.sda_oe, bus.cmd_valid, bus.rd_req, bus.busy, bus.cmd_addr, bus.cmd_data});
        end
        reset = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if ({bus.sda_oe, bus.busy, cv_addr.size(), rr_addr.size()} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL idle_after_reset: oe=%b busy=%b cv=%0d rr=%0d", bus.sda_oe, bus.busy, cv_addr.size(), rr_addr.size());
        end
    endtask

    task automatic test_unlock_write();
        int   c0 = cv_addr.size();
        int   acks = 0;
        logic a;
        i2c_start();
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b required 1", bus.busy); end
        send_byte(8'hA0, a); acks += int'(a);
        send_byte(ADDR_UNLOCK1[15:8], a); acks += int'(a);
        send_byte(ADDR_UNLOCK1[7:0], a); acks += int'(a);
        send_byte(DATA_UNLOCK1, a); acks += int'(a);
        i2c_stop();
        n_checks++;
        if (acks != 4) begin n_fail++; $display("FAIL unlock_acks: got %0d required 4", acks); end
        n_checks++;
        if (cv_addr.size() != c0 + 1) begin n_fail++; $display("FAIL unlock_strobe_count: got %0d required 1", cv_addr.size() - c0); end
        n_checks++;
        if (cv_addr.size() <= c0 || cv_addr[c0] !== ADDR_UNLOCK1 || cv_data[c0] !== DATA_UNLOCK1) begin
            n_fail++; $display("FAIL unlock_strobe: strobe missing or wrong, required addr %h data %h", ADDR_UNLOCK1, DATA_UNLOCK1);
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL busy_after_stop: busy=%b oe=%b required 0 0", bus.busy, bus.sda_oe); end
    endtask

    task automatic test_wrong_addr();
        int c0 = cv_addr.size();
        int r0 = rr_addr.size();
        int o0 = oe_cnt;
        int acks;
        wr_buf[0] = 8'h99;
        write_txn(8'h52, 16'h1234, 1, acks);
        n_checks++;
        if (acks != 0) begin n_fail++; $display("FAIL wrong_addr_acks: got %0d required 0", acks); end
        n_checks++;
        if (oe_cnt != o0) begin n_fail++; $display("FAIL wrong_addr_sda_driven: got %0d clks required 0", oe_cnt - o0); end
        n_checks++;
        if (cv_addr.size() != c0 || rr_addr.size() != r0) begin n_fail++; $display("FAIL wrong_addr_strobes: cv=%0d rr=%0d required 0 0", cv_addr.size() - c0, rr_addr.size() - r0); end
        wr_buf[0] = 8'h77;
        write_txn(8'hA0, 16'h0102, 1, acks);
        n_checks++;
        if (acks != 4 || cv_addr.size() != c0 + 1) begin n_fail++; $display("FAIL after_wrong_addr: acks=%0d strobes=%0d required 4 1", acks, cv_addr.size() - c0); end
        else begin
            n_checks++;
            if (cv_addr[c0] !== 16'h0102 || cv_data[c0] !== 8'h77) begin n_fail++; $display("FAIL after_wrong_addr_strobe: got %h/%h required 0102/77", cv_addr[c0], cv_data[c0]); end
        end
    endtask

    task automatic test_wrap();
        int c0 = cv_addr.size();
        int acks;
        wr_buf[0] = 8'h11; wr_buf[1] = 8'h22;
        write_txn(8'hA0, 16'hFFFF, 2, acks);
        n_checks++;
        if (acks != 5 || cv_addr.size() != c0 + 2) begin n_fail++; $display("FAIL wrap_count: acks=%0d strobes=%0d required 5 2", acks, cv_addr.size() - c0); end
        else begin
            n_checks++;
            if (cv_addr[c0] !== 16'hFFFF || cv_data[c0] !== 8'h11) begin n_fail++; $display("FAIL wrap_first: got %h/%h required FFFF/11", cv_addr[c0], cv_data[c0]); end
            n_checks++;
            if (cv_addr[c0+1] !== 16'h0000 || cv_data[c0+1] !== 8'h22) begin n_fail++; $display("FAIL wrap_second: got %h/%h required 0000/22", cv_addr[c0+1], cv_data[c0+1]); end
        end
    endtask

    // Writes the address, then repeated START and reads n bytes (ACK all but last).
    task automatic test_read(input logic [15:0] addr, input int n, input logic [7:0] d0);
        int         c0 = cv_addr.size();
        int         r0 = rr_addr.size();
        int         base = rr_total;
        int         acks = 0;
        logic       a;
        logic       line;
        logic [7:0] got;
        logic [7:0] exp_b [4];
        for (int k = 0; k < n; k++) begin
            exp_b[k] = (k == 0) ? d0 : 8'($urandom);
            rd_bytes[3'(base + k)] = exp_b[k];
        end
        i2c_start();
        send_byte(8'hA0, a); acks += int'(a);
        send_byte(addr[15:8], a); acks += int'(a);
        send_byte(addr[7:0], a); acks += int'(a);
        i2c_start();
        send_byte(8'hA1, a); acks += int'(a);
        n_checks++;
        if (acks != 4) begin n_fail++; $display("FAIL read_acks: got %0d required 4", acks); end
        for (int k = 0; k < n; k++) begin
            read_byte((k == n - 1) ? I2C_NACK : I2C_ACK, got, line);
            n_checks++;
            if (got !== exp_b[k]) begin n_fail++; $display("FAIL read_byte%0d: got %h required %h", k, got, exp_b[k]); end
        end
        n_checks++;
        if (line !== 1'b1) begin n_fail++; $display("FAIL read_rack_release: SDA got %b required 1", line); end
        i2c_stop();
        n_checks++;
        if (rr_addr.size() != r0 + n || cv_addr.size() != c0) begin
            n_fail++; $display("FAIL read_strobe_count: rd_req=%0d cmd_valid=%0d required %0d 0", rr_addr.size() - r0, cv_addr.size() - c0, n);
        end else begin
            for (int k = 0; k < n; k++) begin
                n_checks++;
                if (rr_addr[r0+k] !== 16'(addr + k)) begin n_fail++; $display("FAIL read_addr%0d: got %h required %h", k, rr_addr[r0+k], 16'(addr + k)); end
            end
        end
    endtask

    task automatic test_partial_stop();
        int   c0 = cv_addr.size();
        int   acks = 0;
        logic a;
        logic seen;
        i2c_start();
        send_byte(8'hA0, a); acks += int'(a);
        send_byte(8'h40, a); acks += int'(a);
        send_byte(8'h00, a); acks += int'(a);
        for (int i = 0; i < 4; i++) i2c_bit(1'b1, seen);
        i2c_stop();
        n_checks++;
        if (acks != 3) begin n_fail++; $display("FAIL partial_acks: got %0d required 3", acks); end
        n_checks++;
        if (cv_addr.size() != c0) begin n_fail++; $display("FAIL partial_no_strobe: got %0d strobes required 0", cv_addr.size() - c0); end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL partial_idle: busy=%b oe=%b required 0 0", bus.busy, bus.sda_oe); end
    endtask

    task automatic test_reset_mid_ack();
        int   c0;
        int   acks;
        logic seen;
        i2c_start();
        for (int i = 7; i >= 0; i--) i2c_bit(1'(8'hA0 >> i), seen);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        n_checks++;
        if (bus.sda_oe !== 1'b1) begin n_fail++; $display("FAIL ack_driven_before_reset: got %b required 1", bus.sda_oe); end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.sda_oe, bus.cmd_valid, bus.rd_req, bus.busy, bus.cmd_addr, bus.cmd_data} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_mid_ack: got %h required 0", {bus.sda_oe, bus.cmd_valid, bus.rd_req, bus.busy, bus.cmd_addr, bus.cmd_data});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        c0 = cv_addr.size();
        wr_buf[0] = 8'h5A;
        write_txn(8'hA0, 16'h0A0B, 1, acks);
        n_checks++;
        if (acks != 4 || cv_addr.size() != c0 + 1) begin n_fail++; $display("FAIL after_reset_txn: acks=%0d strobes=%0d required 4 1", acks, cv_addr.size() - c0); end
        else begin
            n_checks++;
            if (cv_addr[c0] !== 16'h0A0B || cv_data[c0] !== 8'h5A) begin n_fail++; $display("FAIL after_reset_strobe: got %h/%h required 0A0B/5A", cv_addr[c0], cv_data[c0]); end
        end
    endtask

    // Full unlock + write command sequence as back-to-back transactions.
    task automatic test_back_to_back();
        logic [15:0] a_tab [3];
        logic [7:0]  d_tab [3];
        int          c0 = cv_addr.size();
        int          acks;
        a_tab[0] = ADDR_UNLOCK1; d_tab[0] = DATA_UNLOCK1;
        a_tab[1] = ADDR_UNLOCK2; d_tab[1] = DATA_UNLOCK2;
        a_tab[2] = ADDR_UNLOCK1; d_tab[2] = CMD_WRITE;
        for (int t = 0; t < 3; t++) begin
            wr_buf[0] = d_tab[t];
            write_txn(8'hA0, a_tab[t], 1, acks);
        end
        n_checks++;
        if (cv_addr.size() != c0 + 3) begin n_fail++; $display("FAIL b2b_count: got %0d required 3", cv_addr.size() - c0); end
        else begin
            for (int t = 0; t < 3; t++) begin
                n_checks++;
                if (cv_addr[c0+t] !== a_tab[t] || cv_data[c0+t] !== d_tab[t]) begin
                    n_fail++; $display("FAIL b2b_strobe%0d: got %h/%h required %h/%h", t, cv_addr[c0+t], cv_data[c0+t], a_tab[t], d_tab[t]);
                end
            end
        end
    endtask

    task automatic test_random_write();
        for (int it = 0; it < 4; it++) begin
            logic [15:0] addr = 16'($urandom);
            int          n    = int'($urandom_range(1, 4));
            int          c0   = cv_addr.size();
            int          acks;
            if (it == 0) addr = 16'hFFFE;
            for (int k = 0; k < n; k++) wr_buf[k] = 8'($urandom);
            write_txn(8'hA0, addr, n, acks);
            n_checks++;
            if (acks != n + 3 || cv_addr.size() != c0 + n) begin
                n_fail++; $display("FAIL rand_write_count: acks=%0d strobes=%0d required %0d %0d", acks, cv_addr.size() - c0, n + 3, n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    n_checks++;
                    if (cv_addr[c0+k] !== 16'((32'(addr) + k) % 65536) || cv_data[c0+k] !== wr_buf[k]) begin
                        n_fail++; $display("FAIL rand_write%0d: got %h/%h required %h/%h", k, cv_addr[c0+k], cv_data[c0+k], 16'(addr + k), wr_buf[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_no_overlap();
        n_checks++;
        if (both_cnt != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d clks required 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_unlock_write();
        test_wrong_addr();
        test_wrap();
        test_read(16'h1234, 1, 8'h3C);
        test_partial_stop();
        test_reset_mid_ack();
        test_back_to_back();
        test_random_write();
        test_read(16'($urandom), 3, CMD_READ);
        test_read(16'hFFFF, 2, 8'($urandom));
        test_read(16'($urandom), 4, 8'($urandom));
        test_no_overlap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
